// File: rtl/aes256_inv_cipher_ctrl.sv
// Iterative AES-256 decryption round sequencer: one inverse round per clock over a
// single 128-bit state register, round keys fetched by index, plaintext over valid/ready.
module aes256_inv_cipher_ctrl #(
  parameter int unsigned NR = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt_out,
  output logic         busy
);

  localparam logic [3:0] NR4 = 4'(NR);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_e;

  state_e       fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] pt_q, pt_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] ark;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, acc;
    p   = a;
    acc = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8) as x^254 (0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] x, r, p, e;
    x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    r = 8'h01;
    p = x;
    e = 8'd254;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  // Byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int unsigned  src;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        src = r + 4 * ((c + 4 - r) % 4);
        o[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*src -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c      -: 8];
      a1 = s[127 - 32*c -  8 -: 8];
      a2 = s[127 - 32*c - 16 -: 8];
      a3 = s[127 - 32*c - 24 -: 8];
      o[127 - 32*c      -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[127 - 32*c -  8 -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[127 - 32*c - 16 -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[127 - 32*c - 24 -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Shared between ROUND and FINAL; only the trailing InvMixColumns differs.
  always_comb begin
    ark = inv_sub_shift(st_q) ^ rk_in;
  end

  always_comb begin
    fsm_d       = fsm_q;
    st_d        = st_q;
    cnt_d       = cnt_q;
    pt_d        = pt_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    rk_idx      = NR4;
    unique case (fsm_q)
      S_IDLE: begin
        in_ready = key_ready;
        if (in_valid && key_ready) begin
          st_d  = ct_in ^ rk_in;
          cnt_d = NR4 - 4'd1;
          fsm_d = S_ROUND;
        end
      end
      S_ROUND: begin
        rk_idx = cnt_q;
        st_d   = inv_mix_columns(ark);
        if (cnt_q == 4'd1) fsm_d = S_FINAL;
        else               cnt_d = cnt_q - 4'd1;
      end
      S_FINAL: begin
        rk_idx      = '0;
        pt_d        = ark;
        out_valid_d = 1'b1;
        fsm_d       = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = NR4;
          fsm_d       = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      st_q        <= '0;
      cnt_q       <= NR4;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      pt_q        <= pt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pt_out    = pt_q;
  assign busy      = (fsm_q == S_ROUND) || (fsm_q == S_FINAL);

endmodule

// File: tb/tb_aes256_inv_cipher_ctrl.sv
// Bench for aes256_inv_cipher_ctrl: expected plaintexts come from a forward AES-256
// model (blocks are made by encrypting known plaintexts); a cycle model checks handshakes.
module tb_aes256_inv_cipher_ctrl;

  logic         clk = 1'b0;
  logic         rst_n, key_ready, in_valid, out_ready;
  logic         in_ready, out_valid, busy;
  logic [127:0] ct_in, rk_in, pt_out;
  logic [3:0]   rk_idx;

  always #5 clk = ~clk;

  aes256_inv_cipher_ctrl #(.NR(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .rk_idx    (rk_idx),
    .rk_in     (rk_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_out    (pt_out),
    .busy      (busy)
  );

  logic [7:0]   sbox [256];
  logic [127:0] rk_mem [16];
  assign rk_in = rk_mem[rk_idx];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: no DUT response within cycle budget (cycle %0d)", name, cyc);
  endtask

  // ---------------- forward AES-256 reference ----------------
  function automatic logic [7:0] x2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] aa = a, bb = b;
    while (bb != 0) begin
      if (bb[0]) r = r ^ aa;
      aa = x2(aa);
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic key_expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = x2(rcon);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk_mem[15] = '0;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] key, o;
    key = rk_mem[0];
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ key[127 - 8*i -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
      if (rnd < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3;
          s[4*c+3] = x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3);
        end
      end
      key = rk_mem[rnd];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ key[127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- cycle-level expectation model ----------------
  // phase: -1 idle, 0..13 = edges elapsed since acceptance, 14 = holding result
  int           phase = -1;
  logic [127:0] m_exp, m_last, exp_pending;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase  <= -1;
      m_last <= '0;
    end else if (phase == -1) begin
      if (in_valid && key_ready) begin
        phase <= 0;
        m_exp <= exp_pending;
      end
    end else if (phase < 13) begin
      phase <= phase + 1;
    end else if (phase == 13) begin
      phase  <= 14;
      m_last <= m_exp;
    end else if (out_ready) begin
      phase <= -1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, (phase == -1) && key_ready);
      chk("busy", busy, (phase >= 0) && (phase <= 13));
      chk("out_valid", out_valid, phase == 14);
      chk("pt_out", pt_out, m_last);
      if (phase != 14)
        chk("rk_idx", rk_idx, (phase == -1) ? 14 : (phase == 13) ? 0 : 13 - phase);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit hold,
                      output int acc);
    bit ok = 0;
    @(posedge clk); #1;
    ct_in = ct; exp_pending = pt; in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) timeout("accept");
    @(posedge clk); #1;
    acc = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int oc);
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    if (!ok) timeout("out_valid");
    oc = cyc;
  endtask

  task automatic rand_vec(output logic [127:0] pt, output logic [127:0] ct);
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = encrypt(pt);
  endtask

  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

  initial begin
    int acc, oc, oc1;
    bit ok;
    logic [127:0] pt, ct;
    rst_n = 1'b0; key_ready = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ct_in = '0; exp_pending = '0; m_exp = '0; m_last = '0;
    build_sbox();
    key_expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

    chk("sbox_00", sbox[8'h00], 8'h63);
    chk("sbox_53", sbox[8'h53], 8'hed);
    chk("model_fips_encrypt", encrypt(FIPS_PT), FIPS_CT);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_pt_out", pt_out, 128'h0);
    chk("rst_rk_idx", rk_idx, 4'd14);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1;

    // FIPS vector, latency
    key_ready = 1'b1;
    send(FIPS_CT, FIPS_PT, 0, acc);
    wait_out(oc);
    chk("fips_latency", oc - acc, 14);
    chk("fips_pt", pt_out, FIPS_PT);
    repeat (2) @(posedge clk);

    // backpressure
    #1 out_ready = 1'b0;
    rand_vec(pt, ct);
    send(ct, pt, 0, acc);
    wait_out(oc);
    repeat (10) @(negedge clk);
    chk("bp_pt_held", pt_out, pt);
    chk("bp_valid_held", out_valid, 1'b1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_released", out_valid, 1'b0);
    @(posedge clk); #1 out_ready = 1'b1;

    // key gating
    rand_vec(pt, ct);
    key_ready = 1'b0;
    ct_in = ct; exp_pending = pt; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("gate_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 key_ready = 1'b1;
    @(negedge clk);
    chk("gate_open", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("gate_accepted", busy, 1'b1);
    wait_out(oc);
    chk("gate_pt", pt_out, pt);

    // reset mid-block at rk_idx 7
    rand_vec(pt, ct);
    send(ct, pt, 0, acc);
    ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (busy && rk_idx == 4'd7) ok = 1;
    end
    if (!ok) timeout("reach_round7");
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_pt_out", pt_out, 128'h0);
    chk("mid_rst_rk_idx", rk_idx, 4'd14);
    chk("mid_rst_busy", busy, 1'b0);
    rand_vec(pt, ct);
    send(ct, pt, 0, acc);
    wait_out(oc);
    chk("post_rst_pt", pt_out, pt);

    // back-to-back, in_valid held
    send(FIPS_CT, FIPS_PT, 1, acc);
    wait_out(oc1);
    chk("b2b_first_pt", pt_out, FIPS_PT);
    @(negedge clk);
    chk("b2b_idle_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("b2b_second_accept", busy, 1'b1);
    in_valid = 1'b0;
    wait_out(oc);
    chk("b2b_period", oc - oc1, 16);
    chk("b2b_second_pt", pt_out, FIPS_PT);

    // ct_in / in_valid activity while busy is ignored
    rand_vec(pt, ct);
    send(ct, pt, 0, acc);
    #1 ct_in = ~ct; in_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(oc);
    chk("ignored_ct_pt", pt_out, pt);

    // a few more random blocks
    for (int k = 0; k < 3; k++) begin
      rand_vec(pt, ct);
      send(ct, pt, 0, acc);
      wait_out(oc);
      chk("rand_pt", pt_out, pt);
    end

    repeat (3) @(posedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
